// File: rtl/lifo_stack.sv
// LIFO stack of DATA_WIDTH-bit words with a registered pop output.
// Illegal requests produce a one-cycle error pulse and leave all state untouched.
module lifo_stack #(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  error,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    count
);

    localparam int unsigned CNT_W = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        REQ_IDLE = 2'b00,
        REQ_POP  = 2'b01,
        REQ_PUSH = 2'b10,
        REQ_BOTH = 2'b11
    } req_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]      count_q,    count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  error_q,    error_d;

    logic                  full_w;
    logic                  empty_w;
    logic                  wr_en;
    logic [PTR_WIDTH-1:0]  wr_addr;
    logic [PTR_WIDTH-1:0]  rd_addr;
    logic [CNT_W-1:0]      count_m1;
    req_e                  req;

    assign full_w   = (count_q == CNT_FULL);
    assign empty_w  = (count_q == '0);
    assign count_m1 = count_q - CNT_ONE;
    // Both addresses are only consumed when the count is in range, so truncation is safe.
    assign wr_addr  = count_q[PTR_WIDTH-1:0];
    assign rd_addr  = count_m1[PTR_WIDTH-1:0];
    assign req      = req_e'({push, pop});

    always_comb begin
        count_d    = count_q;
        data_out_d = data_out_q;
        error_d    = 1'b0;
        wr_en      = 1'b0;
        unique case (req)
            REQ_PUSH: begin
                if (full_w) begin
                    error_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_ONE;
                end
            end
            REQ_POP: begin
                if (empty_w) begin
                    error_d = 1'b1;
                end else begin
                    data_out_d = mem_q[rd_addr];
                    count_d    = count_m1;
                end
            end
            REQ_BOTH: error_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            data_out_q <= '0;
            error_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign error    = error_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: a queue model predicts state, and a
// scoreboard holds expected pop data until the DUT presents it.
module tb_lifo_stack;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          error;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    lifo_stack #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (data_in),
        .data_out(data_out),
        .error   (error),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [DW-1:0] mdl[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"},    32'(count),    32'(mdl.size()));
        check({tag, ".empty"},    32'(empty),    32'(mdl.size() == 0));
        check({tag, ".full"},     32'(full),     32'(mdl.size() == DEPTH));
        check({tag, ".error"},    32'(error),    32'(exp_err));
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input string tag, input logic p, input logic q, input logic [DW-1:0] d);
        bit did_pop = 0;
        push    = p;
        pop     = q;
        data_in = d;
        exp_err = 1'b0;
        if (p && q) begin
            exp_err = 1'b1;
        end else if (p) begin
            if (mdl.size() == DEPTH) exp_err = 1'b1;
            else mdl.push_back(d);
        end else if (q) begin
            if (mdl.size() == 0) begin
                exp_err = 1'b1;
            end else begin
                sb.push_back(mdl.pop_back());
                did_pop = 1;
            end
        end
        @(posedge clk);
        #1;
        if (did_pop) begin
            exp_dout = sb.pop_front();
            check({tag, ".pop_data"}, 32'(data_out), 32'(exp_dout));
        end
        check_state(tag);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles
        repeat (2) begin
            @(negedge clk);
            check_state("reset");
        end
        reset = 1'b1;

        cycle("push_aa", 1'b1, 1'b0, 8'hAA);
        cycle("idle", 1'b0, 1'b0, 8'h00);
        cycle("idle", 1'b0, 1'b0, 8'h00);
        cycle("pop_aa", 1'b0, 1'b1, 8'h00);

        cycle("push_11", 1'b1, 1'b0, 8'h11);
        cycle("push_22", 1'b1, 1'b0, 8'h22);
        cycle("push_33", 1'b1, 1'b0, 8'h33);
        for (int i = 0; i < 3; i++) cycle("lifo_pop", 1'b0, 1'b1, 8'h00);

        cycle("pop_empty", 1'b0, 1'b1, 8'h00);
        cycle("after_err", 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 1'b0, 8'(i));
        cycle("push_full", 1'b1, 1'b0, 8'hEE);
        cycle("push_full2", 1'b1, 1'b0, 8'hEF);
        cycle("pop_after_full", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 13; i++) cycle("drain", 1'b0, 1'b1, 8'h00);

        cycle("both", 1'b1, 1'b1, 8'h77);
        cycle("pop_prev_top", 1'b0, 1'b1, 8'h00);
        cycle("pop_last", 1'b0, 1'b1, 8'h00);

        cycle("pre_push_a", 1'b1, 1'b0, 8'h5A);
        cycle("pre_push_b", 1'b1, 1'b0, 8'hC3);
        cycle("pre_pop", 1'b0, 1'b1, 8'h00);
        cycle("pre_push_c", 1'b1, 1'b0, 8'h3C);
        cycle("pre_push_d", 1'b1, 1'b0, 8'h96);
        cycle("pre_both", 1'b1, 1'b1, 8'h00);

        // Asynchronous reset between clock edges, no clock edge needed
        #2;
        reset = 1'b0;
        #1;
        mdl.delete();
        sb.delete();
        exp_dout = '0;
        exp_err  = 1'b0;
        check_state("async_reset");
        @(negedge clk);
        reset = 1'b1;
        cycle("pop_after_reset", 1'b0, 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Synchronous LIFO stack of DATA_WIDTH-bit words with push/pop controls.
- A pop places the top entry on a registered output.
- Illegal operations raise a one-cycle error pulse: push when full, pop when empty, or push and pop together.
- Standalone storage block for datapaths that need last-in/first-out buffering.

Parameters:
DATA_WIDTH, 8, width of each stored word and of data_in/data_out
DEPTH, 16, number of entries; must be a power of two and at least 2
PTR_WIDTH, $clog2(DEPTH), derived, width of the internal stack pointer; not overridden by the user

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
push  input  1  push request, sampled on rising clk
pop  input  1  pop request, sampled on rising clk
data_in  input  DATA_WIDTH  word written on a legal push
data_out  output  DATA_WIDTH  registered word from the most recent legal pop
error  output  1  registered one-cycle pulse flagging an illegal request
full  output  1  high when count == DEPTH
empty  output  1  high when count == 0
count  output  PTR_WIDTH+1  number of valid entries (0..DEPTH)

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array plus a count/pointer register. The top of stack is entry count-1.
- Reset (reset=0, asynchronous, no clock required):
  - count=0, data_out=0, error=0, so empty=1 and full=0.
  - Array contents are not cleared.
  - Reset overrides any request, including one in the same cycle.
- All requests are evaluated at the rising clk edge while reset=1.
- Legal push (push=1, pop=0, full=0): mem[count] <= data_in; count <= count+1; data_out unchanged; error <= 0.
- Legal pop (pop=1, push=0, empty=0): data_out <= mem[count-1]; count <= count-1; error <= 0. data_out is valid from the edge that performs the pop (latency 1 cycle from request sample) and holds until the next legal pop or reset.
- Push when full: no write, count unchanged, data_out unchanged, error <= 1.
- Pop when empty: count unchanged, data_out unchanged, error <= 1.
- push=1 and pop=1 together:
  - Always illegal, regardless of fill level.
  - No write, count unchanged, data_out unchanged, error <= 1.
- Idle (push=0, pop=0): all state holds; error <= 0.
- error is not sticky. It is high for exactly one cycle per illegal request; back-to-back illegal requests keep it high.
- full and empty are combinational decodes of count. No wrap-around is possible, because the count saturates by rejecting requests.
- Only a legal push changes stored contents. Popped entries are not cleared.
- Pulse width: push/pop held high for N cycles means N requests.

Test Plan:
- Reset hold then release: reset=0 for 2 cycles -> data_out=0x00, error=0, empty=1, full=0, count=0.
- Push 0xAA for 1 cycle, idle 2 cycles, pop for 1 cycle:
  - After the push edge: count=1, empty=0.
  - After the pop edge: data_out=0xAA, count=0, empty=1, error=0 throughout.
- LIFO order: push 0x11, 0x22, 0x33, then pop x3 -> data_out sequence 0x33, 0x22, 0x11; error stays 0.
- Boundaries:
  - Pop on empty -> error=1 for exactly one cycle, data_out and count unchanged.
  - Push 16 words 0x00..0x0F -> full=1, count=16.
  - 17th push -> error=1, count stays 16.
  - Subsequent pop -> data_out=0x0F.
- Simultaneous push=1, pop=1 with count=2 -> error=1, count stays 2, data_out unchanged, next pop returns the previous top.
- Asynchronous reset mid-operation: after 3 pushes, drive reset=0 between clock edges -> count=0, data_out=0, error=0 immediately. After release, pop -> error=1.
